// File: rtl/tof_pulse_train_pkg.sv
// Shared types and defaults for the laser pulse-train generator.
package tof_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

endpackage

// File: rtl/tof_pulse_train_if.sv
// Bundles the trigger/config inputs and status outputs of tof_pulse_train.
interface tof_pulse_train_if
  import tof_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             trig;
  logic             enable;
  logic [CNT_W-1:0] delay_cyc;
  logic [CNT_W-1:0] width_cyc;
  logic [CNT_W-1:0] period_cyc;
  logic [CNT_W-1:0] num_pulses;
  logic             laser_out;
  logic             busy;
  logic             done_pulse;
  logic             overrun_pulse;

  modport master (
    output trig, enable, delay_cyc, width_cyc, period_cyc, num_pulses,
    input  laser_out, busy, done_pulse, overrun_pulse
  );

  modport slave (
    input  trig, enable, delay_cyc, width_cyc, period_cyc, num_pulses,
    output laser_out, busy, done_pulse, overrun_pulse
  );

endinterface

// File: rtl/tof_pulse_train.sv
// Time-of-flight laser pulse-train generator: after a trigger, waits a
// programmed delay, then emits a burst of N pulses of fixed width/period.
module tof_pulse_train
  import tof_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trig,
  input  logic             enable,
  input  logic [CNT_W-1:0] delay_cyc,
  input  logic [CNT_W-1:0] width_cyc,
  input  logic [CNT_W-1:0] period_cyc,
  input  logic [CNT_W-1:0] num_pulses,
  output logic             laser_out,
  output logic             busy,
  output logic             done_pulse,
  output logic             overrun_pulse
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] we_r;
  logic [CNT_W-1:0] pe_r;
  logic [CNT_W-1:0] last_r;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] dly;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] we_in;
  logic [CNT_W-1:0] pe_in;

  // Effective width (at least one cycle) and period (strictly longer than
  // the width, saturating at the counter maximum).
  always_comb begin
    we_in = (width_cyc == '0) ? ONE : width_cyc;
    if (period_cyc > we_in) begin
      pe_in = period_cyc;
    end else if (we_in == MAX) begin
      pe_in = MAX;
    end else begin
      pe_in = we_in + ONE;
    end
  end

  // Burst sequencer; every output is a flop updated alongside the state.
  // phase counts from the first high cycle of a pulse up to the end of its
  // period; LOW uses >= so a saturated period (Pe == We) still terminates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      we_r          <= '0;
      pe_r          <= '0;
      last_r        <= '0;
      phase         <= '0;
      dly           <= '0;
      idx           <= '0;
      laser_out     <= 1'b0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      overrun_pulse <= 1'b0;
    end else begin
      done_pulse    <= 1'b0;
      overrun_pulse <= 1'b0;
      if (state != IDLE && enable && trig) begin
        overrun_pulse <= 1'b1;
      end
      if (state != IDLE && !enable) begin
        state     <= IDLE;
        laser_out <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enable && trig) begin
              we_r   <= we_in;
              pe_r   <= pe_in;
              last_r <= num_pulses - ONE;
              idx    <= '0;
              phase  <= '0;
              if (num_pulses == '0) begin
                done_pulse <= 1'b1;
              end else if (delay_cyc == '0) begin
                state     <= HIGH;
                laser_out <= 1'b1;
                busy      <= 1'b1;
              end else begin
                state <= DELAY;
                dly   <= delay_cyc - ONE;
                busy  <= 1'b1;
              end
            end
          end
          DELAY: begin
            if (dly == '0) begin
              state     <= HIGH;
              laser_out <= 1'b1;
              phase     <= '0;
            end else begin
              dly <= dly - ONE;
            end
          end
          HIGH: begin
            if (phase == we_r - ONE) begin
              laser_out <= 1'b0;
              if (idx == last_r) begin
                state      <= IDLE;
                busy       <= 1'b0;
                done_pulse <= 1'b1;
              end else begin
                state <= LOW;
                phase <= phase + ONE;
              end
            end else begin
              phase <= phase + ONE;
            end
          end
          LOW: begin
            if (phase >= pe_r - ONE) begin
              state     <= HIGH;
              laser_out <= 1'b1;
              phase     <= '0;
              idx       <= idx + ONE;
            end else begin
              phase <= phase + ONE;
            end
          end
          default: begin
            state     <= IDLE;
            laser_out <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tof_pulse_train.sv
// Directed bench for tof_pulse_train: per-cycle traces of each output are
// packed into bit masks (bit c = cycle c after the trigger cycle 0) and
// compared with hand-derived masks.
module tb_tof_pulse_train;

  localparam int unsigned W16 = 16;
  localparam int unsigned W4  = 4;

  logic clk;
  logic rst_n;

  tof_pulse_train_if #(.CNT_W(W16)) bus ();

  tof_pulse_train #(.CNT_W(W16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trig          (bus.trig),
    .enable        (bus.enable),
    .delay_cyc     (bus.delay_cyc),
    .width_cyc     (bus.width_cyc),
    .period_cyc    (bus.period_cyc),
    .num_pulses    (bus.num_pulses),
    .laser_out     (bus.laser_out),
    .busy          (bus.busy),
    .done_pulse    (bus.done_pulse),
    .overrun_pulse (bus.overrun_pulse)
  );

  // Narrow instance so the full-count pulse index case fits in a short run.
  logic          trig4;
  logic          enable4;
  logic [W4-1:0] d4, w4, p4, n4;
  logic          laser4, busy4, done4, ovr4;

  tof_pulse_train #(.CNT_W(W4)) dut4 (
    .clk           (clk),
    .rst_n         (rst_n),
    .trig          (trig4),
    .enable        (enable4),
    .delay_cyc     (d4),
    .width_cyc     (w4),
    .period_cyc    (p4),
    .num_pulses    (n4),
    .laser_out     (laser4),
    .busy          (busy4),
    .done_pulse    (done4),
    .overrun_pulse (ovr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] lm, bm, dm, om;

  // Runs one scenario: trig high in cycles set in tmask, enable low only in
  // cycle en_off, rst_n low only in cycle rst_at (-1 = never). Inputs are
  // scrambled during cycles 1-2 to show the burst uses captured values.
  task automatic capture(input logic [15:0] d, input logic [15:0] w,
                         input logic [15:0] p, input logic [15:0] n,
                         input logic [63:0] tmask, input int en_off,
                         input int rst_at, input int ncyc);
    lm = '0; bm = '0; dm = '0; om = '0;
    @(posedge clk); #1;
    bus.delay_cyc  = d;
    bus.width_cyc  = w;
    bus.period_cyc = p;
    bus.num_pulses = n;
    bus.trig       = tmask[0];
    bus.enable     = (en_off != 0);
    #1;
    lm[0] = bus.laser_out; bm[0] = bus.busy;
    dm[0] = bus.done_pulse; om[0] = bus.overrun_pulse;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.trig   = tmask[c];
      bus.enable = (en_off != c);
      rst_n      = (rst_at != c);
      if (c == 1) begin
        bus.delay_cyc = 16'd7; bus.width_cyc = 16'd1;
        bus.period_cyc = 16'd9; bus.num_pulses = 16'd1;
      end
      if (c == 3) begin
        bus.delay_cyc = d; bus.width_cyc = w;
        bus.period_cyc = p; bus.num_pulses = n;
      end
      #1;
      lm[c] = bus.laser_out; bm[c] = bus.busy;
      dm[c] = bus.done_pulse; om[c] = bus.overrun_pulse;
    end
    bus.trig = 1'b0; bus.enable = 1'b1; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.laser_out, bus.busy, bus.done_pulse, bus.overrun_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0000",
               {bus.laser_out, bus.busy, bus.done_pulse, bus.overrun_pulse});
    end
    n_checks++;
    if ({laser4, busy4, done4, ovr4} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs4 got %b want 0000", {laser4, busy4, done4, ovr4});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.laser_out, bus.busy, bus.done_pulse, bus.overrun_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b want 0000",
               {bus.laser_out, bus.busy, bus.done_pulse, bus.overrun_pulse});
    end
  endtask

  task automatic test_basic(input string tag);
    capture(16'd3, 16'd2, 16'd5, 16'd3, 64'h1, -1, -1, 20);
    n_checks++; if (lm !== 64'hC630)  begin n_fail++; $display("FAIL %s_laser got %h want %h", tag, lm, 64'hC630); end
    n_checks++; if (bm !== 64'hFFFE)  begin n_fail++; $display("FAIL %s_busy got %h want %h", tag, bm, 64'hFFFE); end
    n_checks++; if (dm !== 64'h10000) begin n_fail++; $display("FAIL %s_done got %h want %h", tag, dm, 64'h10000); end
    n_checks++; if (om !== 64'h0)     begin n_fail++; $display("FAIL %s_overrun got %h want 0", tag, om); end
  endtask

  task automatic test_min_width();
    capture(16'd0, 16'd0, 16'd0, 16'd2, 64'h1, -1, -1, 8);
    n_checks++; if (lm !== 64'hA)  begin n_fail++; $display("FAIL minw_laser got %h want %h", lm, 64'hA); end
    n_checks++; if (bm !== 64'hE)  begin n_fail++; $display("FAIL minw_busy got %h want %h", bm, 64'hE); end
    n_checks++; if (dm !== 64'h10) begin n_fail++; $display("FAIL minw_done got %h want %h", dm, 64'h10); end
  endtask

  task automatic test_zero_pulses();
    capture(16'd3, 16'd2, 16'd5, 16'd0, 64'h1, -1, -1, 5);
    n_checks++; if (lm !== 64'h0) begin n_fail++; $display("FAIL zeron_laser got %h want 0", lm); end
    n_checks++; if (bm !== 64'h0) begin n_fail++; $display("FAIL zeron_busy got %h want 0", bm); end
    n_checks++; if (dm !== 64'h2) begin n_fail++; $display("FAIL zeron_done got %h want %h", dm, 64'h2); end
  endtask

  task automatic test_back_to_back();
    capture(16'd3, 16'd2, 16'd5, 16'd3, 64'h1_0041, -1, -1, 34);
    n_checks++; if (lm !== 64'hC630_C630)   begin n_fail++; $display("FAIL b2b_laser got %h want %h", lm, 64'hC630_C630); end
    n_checks++; if (bm !== 64'hFFFE_FFFE)   begin n_fail++; $display("FAIL b2b_busy got %h want %h", bm, 64'hFFFE_FFFE); end
    n_checks++; if (dm !== 64'h1_0001_0000) begin n_fail++; $display("FAIL b2b_done got %h want %h", dm, 64'h1_0001_0000); end
    n_checks++; if (om !== 64'h80)          begin n_fail++; $display("FAIL b2b_overrun got %h want %h", om, 64'h80); end
  endtask

  task automatic test_enable_abort();
    capture(16'd3, 16'd2, 16'd5, 16'd3, 64'h1, 9, -1, 20);
    n_checks++; if (lm !== 64'h230) begin n_fail++; $display("FAIL abort_laser got %h want %h", lm, 64'h230); end
    n_checks++; if (bm !== 64'h3FE) begin n_fail++; $display("FAIL abort_busy got %h want %h", bm, 64'h3FE); end
    n_checks++; if (dm !== 64'h0)   begin n_fail++; $display("FAIL abort_done got %h want 0", dm); end
  endtask

  task automatic test_trig_disabled();
    capture(16'd3, 16'd2, 16'd5, 16'd3, 64'h1, 0, -1, 6);
    n_checks++; if ((lm | bm | dm) !== 64'h0) begin n_fail++; $display("FAIL dis_activity got %h want 0", lm | bm | dm); end
    n_checks++; if (om !== 64'h0) begin n_fail++; $display("FAIL dis_overrun got %h want 0", om); end
  endtask

  task automatic test_reset_mid_burst();
    capture(16'd3, 16'd2, 16'd5, 16'd3, 64'h1, -1, 5, 10);
    n_checks++; if (lm !== 64'h10) begin n_fail++; $display("FAIL rstmid_laser got %h want %h", lm, 64'h10); end
    n_checks++; if (bm !== 64'h1E) begin n_fail++; $display("FAIL rstmid_busy got %h want %h", bm, 64'h1E); end
    n_checks++; if ((dm | om) !== 64'h0) begin n_fail++; $display("FAIL rstmid_flags got %h want 0", dm | om); end
    test_basic("rerun");
  endtask

  task automatic test_max_count();
    logic [63:0] l4, b4, f4;
    l4 = '0; b4 = '0; f4 = '0;
    @(posedge clk); #1;
    d4 = 4'd0; w4 = 4'd0; p4 = 4'd0; n4 = 4'd15; trig4 = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      trig4 = 1'b0;
      #1;
      l4[c] = laser4; b4[c] = busy4; f4[c] = done4;
    end
    n_checks++; if (l4 !== 64'h2AAA_AAAA) begin n_fail++; $display("FAIL maxn_laser got %h want %h", l4, 64'h2AAA_AAAA); end
    n_checks++; if (b4 !== 64'h3FFF_FFFE) begin n_fail++; $display("FAIL maxn_busy got %h want %h", b4, 64'h3FFF_FFFE); end
    n_checks++; if (f4 !== 64'h4000_0000) begin n_fail++; $display("FAIL maxn_done got %h want %h", f4, 64'h4000_0000); end
  endtask

  initial begin
    bus.trig = 1'b0; bus.enable = 1'b1;
    bus.delay_cyc = '0; bus.width_cyc = '0; bus.period_cyc = '0; bus.num_pulses = '0;
    trig4 = 1'b0; enable4 = 1'b1; d4 = '0; w4 = '0; p4 = '0; n4 = '0;
    test_reset();
    test_basic("basic");
    test_min_width();
    test_zero_pulses();
    test_back_to_back();
    test_enable_abort();
    test_trig_disabled();
    test_reset_mid_burst();
    test_max_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
